phase_bank: RTL and testbench

Double-buffered, parametrised per-channel phase store for the transducer array. Host-parsed phase, calibration and enable words are written into a shadow bank. On `commit`, the whole frame is applied atomically at the next PWM period boundary. The calibration offset is added modulo the PWM period, giving every `pwm` instance a glitch-free, frame-consistent phase and enable. It sits between `receiver` and the `pwm` channel array on the PWM clock, replacing the per-channel `phase_parser` registers and the free-running calibration adder.

---
 rtl/phase_bank.sv | 173 +++++++++++++++++
 tb/tb_phase_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_bank.sv
// phase_bank
// Double-buffered per-channel phase store feeding the pwm channel array.
// Host writes land in a shadow bank; a commit copies the whole shadow bank
// into the active bank at the next PWM period boundary, so every channel
// switches to the new frame on the same period.
//
// Ports
//   clk, rst        PWM clock, synchronous active-high reset
//   wr_valid/ready  write handshake (ready only while idle)
//   wr_sel          0 phase, 1 calibration, 2 enable (wr_data[0]), 3 reserved
//   wr_chan         target channel
//   wr_data         write value
//   commit          request to apply the shadow bank at the next boundary
//   cnt             PWM counter from sync_sender
//   commit_pending  commit waiting for the boundary
//   commit_done     one-cycle pulse when new outputs are valid
//   wr_error        one-cycle pulse the cycle after a rejected write
//   frame_cnt       number of committed frames (wraps)
//   phase_out       calibrated active phase per channel, (phase+cal) mod P
//   en_out          active enable per channel
module phase_bank #(
    parameter int NUM_CHANNELS = 128,
    parameter int CLK_CNT_W    = 8,
    parameter int CLK_CNT_MAX  = 199,
    parameter int CHAN_W       = $clog2(NUM_CHANNELS),
    parameter int FRAME_W      = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [1:0]                             wr_sel,
    input  logic [CHAN_W-1:0]                      wr_chan,
    input  logic [CLK_CNT_W-1:0]                   wr_data,
    input  logic                                   commit,
    input  logic [CLK_CNT_W-1:0]                   cnt,
    output logic                                   commit_pending,
    output logic                                   commit_done,
    output logic                                   wr_error,
    output logic [FRAME_W-1:0]                     frame_cnt,
    output logic [NUM_CHANNELS-1:0][CLK_CNT_W-1:0] phase_out,
    output logic [NUM_CHANNELS-1:0]                en_out
);

    localparam logic [CLK_CNT_W:0]   PERIOD   = (CLK_CNT_W+1)'(CLK_CNT_MAX + 1);
    localparam logic [CLK_CNT_W-1:0] CNT_LAST = CLK_CNT_W'(CLK_CNT_MAX);
    localparam logic [CHAN_W:0]      NUM_CH_L = (CHAN_W+1)'(NUM_CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    state_t               state_reg;
    logic                 wr_ready_reg;
    logic                 commit_pending_reg;
    logic                 commit_done_reg;
    logic                 wr_error_reg;
    logic [FRAME_W-1:0]   frame_cnt_reg;

    logic wr_fire;
    logic chan_bad;
    logic data_bad;
    logic wr_ok;
    logic load_active;

    assign wr_fire  = wr_valid && wr_ready_reg;
    assign chan_bad = ({1'b0, wr_chan} >= NUM_CH_L);
    // Phase and calibration must already be inside the PWM period.
    assign data_bad = (wr_sel[1] == 1'b0) && (wr_data > CNT_LAST);
    assign wr_ok    = wr_fire && !chan_bad && !data_bad && (wr_sel != 2'd3);

    // The whole active bank is loaded on the last count of the period, so
    // the new values are presented from the first count of the next one.
    assign load_active = (state_reg == ST_PENDING) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            wr_ready_reg       <= 1'b0;
            commit_pending_reg <= 1'b0;
            commit_done_reg    <= 1'b0;
            wr_error_reg       <= 1'b0;
            frame_cnt_reg      <= '0;
        end else begin
            commit_done_reg <= 1'b0;
            wr_error_reg    <= wr_fire && !wr_ok;
            case (state_reg)
                ST_IDLE: begin
                    if (commit) begin
                        state_reg          <= ST_PENDING;
                        commit_pending_reg <= 1'b1;
                        wr_ready_reg       <= 1'b0;
                    end else begin
                        wr_ready_reg       <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    // Further commits here are simply ignored.
                    if (load_active) begin
                        state_reg          <= ST_APPLY;
                        commit_pending_reg <= 1'b0;
                        commit_done_reg    <= 1'b1;
                        frame_cnt_reg      <= frame_cnt_reg + FRAME_W'(1);
                    end
                end
                ST_APPLY: begin
                    state_reg    <= ST_IDLE;
                    wr_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    wr_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready       = wr_ready_reg;
    assign commit_pending = commit_pending_reg;
    assign commit_done    = commit_done_reg;
    assign wr_error       = wr_error_reg;
    assign frame_cnt      = frame_cnt_reg;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        logic [CLK_CNT_W-1:0] sh_phase_reg;
        logic [CLK_CNT_W-1:0] sh_cal_reg;
        logic                 sh_en_reg;
        logic [CLK_CNT_W-1:0] act_phase_reg;
        logic [CLK_CNT_W-1:0] act_cal_reg;
        logic                 act_en_reg;
        logic                 hit;
        logic [CLK_CNT_W:0]   sum;

        assign hit = wr_ok && (wr_chan == CHAN_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                sh_phase_reg  <= '0;
                sh_cal_reg    <= '0;
                sh_en_reg     <= 1'b0;
                act_phase_reg <= '0;
                act_cal_reg   <= '0;
                act_en_reg    <= 1'b0;
            end else begin
                // Writes only happen while idle and loads only while
                // pending, so the two never collide.
                if (hit) begin
                    case (wr_sel)
                        2'd0:    sh_phase_reg <= wr_data;
                        2'd1:    sh_cal_reg   <= wr_data;
                        2'd2:    sh_en_reg    <= wr_data[0];
                        default: ;
                    endcase
                end
                if (load_active) begin
                    act_phase_reg <= sh_phase_reg;
                    act_cal_reg   <= sh_cal_reg;
                    act_en_reg    <= sh_en_reg;
                end
            end
        end

        // Both operands are below P, so one conditional subtract is enough
        // to fold the sum back into the period.
        assign sum           = {1'b0, act_phase_reg} + {1'b0, act_cal_reg};
        assign phase_out[gi] = (sum >= PERIOD) ? CLK_CNT_W'(sum - PERIOD)
                                               : CLK_CNT_W'(sum);
        assign en_out[gi]    = act_en_reg;
    end

endmodule

// File: tb/tb_phase_bank.sv
module tb_phase_bank;

    localparam int NCH = 12;
    localparam int P   = 200;

    logic              clk;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [1:0]        wr_sel;
    logic [3:0]        wr_chan;
    logic [7:0]        wr_data;
    logic              commit;
    logic [7:0]        cnt = 8'd0;
    logic              commit_pending;
    logic              commit_done;
    logic              wr_error;
    logic [15:0]       frame_cnt;
    logic [NCH-1:0][7:0] phase_out;
    logic [NCH-1:0]    en_out;

    int total = 0;
    int bad   = 0;

    int sh_p [NCH];
    int sh_c [NCH];
    int sh_e [NCH];
    logic [NCH*8-1:0] exp_vec;
    logic [NCH-1:0]   exp_en;
    int               exp_frame;

    phase_bank #(
        .NUM_CHANNELS(NCH),
        .CLK_CNT_W(8),
        .CLK_CNT_MAX(P-1),
        .FRAME_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_sel(wr_sel),
        .wr_chan(wr_chan),
        .wr_data(wr_data),
        .commit(commit),
        .cnt(cnt),
        .commit_pending(commit_pending),
        .commit_done(commit_done),
        .wr_error(wr_error),
        .frame_cnt(frame_cnt),
        .phase_out(phase_out),
        .en_out(en_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for sync_sender: free-running PWM counter.
    always @(posedge clk) cnt <= (cnt == 8'(P-1)) ? 8'd0 : cnt + 8'd1;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear;
        for (int i = 0; i < NCH; i++) begin
            sh_p[i] = 0;
            sh_c[i] = 0;
            sh_e[i] = 0;
        end
        exp_vec   = '0;
        exp_en    = '0;
        exp_frame = 0;
    endtask

    task automatic do_write(input logic [1:0] sel, input int ch, input int d);
        bit e;
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_chan  = 4'(ch);
        wr_data  = 8'(d);
        tick;
        wr_valid = 1'b0;
        e = (ch >= NCH) || (sel == 2'd3) || (sel < 2'd2 && d > P-1);
        $display("write sel=%0d ch=%0d data=%0d err=%0b", sel, ch, d, wr_error);
        chk("wr_error", {127'd0, wr_error}, {127'd0, e});
        if (!e) begin
            case (sel)
                2'd0: sh_p[ch] = d;
                2'd1: sh_c[ch] = d;
                2'd2: sh_e[ch] = d % 2;
                default: ;
            endcase
        end
    endtask

    // Starts at the negedge of the cycle in which commit is sampled.
    task automatic do_commit(input bit extra, input bit hold);
        int n;
        int c0;
        int expn;
        bit saw_err;
        logic [NCH*8-1:0] old_vec;
        logic [NCH*8-1:0] new_vec;
        logic [NCH-1:0]   new_en;
        old_vec = exp_vec;
        for (int i = 0; i < NCH; i++) begin
            new_vec[i*8 +: 8] = 8'((sh_p[i] + sh_c[i]) % P);
            new_en[i]         = (sh_e[i] != 0);
        end
        c0   = int'(cnt);
        expn = (c0 == P-1) ? P : (P-1) - c0;
        commit = 1'b1;
        tick;
        commit = 1'b0;
        chk("pend_t1", {127'd0, commit_pending}, 128'd1);
        chk("ready_t1", {127'd0, wr_ready}, 128'd0);
        if (hold) begin
            wr_valid = 1'b1;
            wr_sel   = 2'd3;
            wr_chan  = 4'd0;
            wr_data  = 8'd0;
        end
        n = 1;
        saw_err = 1'b0;
        while (cnt != 8'(P-1) && n < 2*P) begin
            commit = (extra && n == 3);
            saw_err |= wr_error;
            tick;
            n++;
        end
        commit = 1'b0;
        saw_err |= wr_error;
        chk("boundary_latency", 128'(n), 128'(expn));
        chk("pend_at_b", {127'd0, commit_pending}, 128'd1);
        chk("phase_old_at_b", 128'(phase_out), 128'(old_vec));
        tick;
        saw_err |= wr_error;
        chk("done_b1", {127'd0, commit_done}, 128'd1);
        chk("pend_b1", {127'd0, commit_pending}, 128'd0);
        chk("ready_b1", {127'd0, wr_ready}, 128'd0);
        chk("phase_b1", 128'(phase_out), 128'(new_vec));
        chk("en_b1", 128'(en_out), 128'(new_en));
        chk("frame_b1", 128'(frame_cnt), 128'(16'(exp_frame + 1)));
        tick;
        chk("ready_b2", {127'd0, wr_ready}, 128'd1);
        chk("done_b2", {127'd0, commit_done}, 128'd0);
        chk("pend_b2", {127'd0, commit_pending}, 128'd0);
        exp_vec   = new_vec;
        exp_en    = new_en;
        exp_frame = exp_frame + 1;
        if (hold) begin
            saw_err |= wr_error;
            chk("held_wr_not_early", {127'd0, saw_err}, 128'd0);
            tick;
            wr_valid = 1'b0;
            chk("held_wr_at_b2", {127'd0, wr_error}, 128'd1);
        end
        $display("commit cnt0=%0d latency=%0d frame=%0d", c0, n, frame_cnt);
    endtask

    task automatic wait_cnt(input int v);
        int k;
        k = 0;
        while (cnt != 8'(v) && k < 2*P) begin
            tick;
            k++;
        end
        chk("wait_cnt", 128'(cnt), 128'(v));
    endtask

    initial begin
        bit saw_done;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_sel   = 2'd0;
        wr_chan  = 4'd0;
        wr_data  = 8'd0;
        commit   = 1'b0;
        model_clear();

        // Reset state
        repeat (3) tick;
        chk("rst_ready", {127'd0, wr_ready}, 128'd0);
        chk("rst_pend", {127'd0, commit_pending}, 128'd0);
        chk("rst_frame", 128'(frame_cnt), 128'd0);
        chk("rst_phase", 128'(phase_out), 128'd0);
        chk("rst_en", 128'(en_out), 128'd0);
        rst = 1'b0;
        tick;
        chk("ready_after_rst", {127'd0, wr_ready}, 128'd1);

        // Five zero writes then a commit
        for (int i = 0; i < 5; i++) do_write(2'd0, i, 0);
        do_commit(1'b0, 1'b0);

        // Phase 150 + cal 100 on ch 3 wraps to 50
        do_write(2'd0, 3, 150);
        do_write(2'd1, 3, 100);
        do_write(2'd2, 3, 1);
        do_commit(1'b0, 1'b0);
        chk("ch3_phase", 128'(phase_out[3]), 128'd50);
        chk("ch3_en", 128'(en_out), 128'h008);

        // Boundary sums
        do_write(2'd0, 0, 199);
        do_write(2'd1, 0, 0);
        do_write(2'd0, 1, 199);
        do_write(2'd1, 1, 1);
        do_write(2'd0, 2, 100);
        do_write(2'd1, 2, 100);
        do_commit(1'b0, 1'b0);
        chk("ch0_199", 128'(phase_out[0]), 128'd199);
        chk("ch1_wrap0", 128'(phase_out[1]), 128'd0);
        chk("ch2_wrap0", 128'(phase_out[2]), 128'd0);

        // Rejected writes leave the bank unchanged
        do_write(2'd0, NCH, 5);
        do_write(2'd0, 4, 200);
        do_write(2'd1, 4, 200);
        do_write(2'd3, 4, 7);
        do_write(2'd0, 4, 199);
        do_commit(1'b0, 1'b0);
        chk("ch4_ok", 128'(phase_out[4]), 128'd199);

        // Commit on cnt==199 waits a full period; extra commit ignored;
        // held write not accepted until b+2
        do_write(2'd0, 5, 10);
        do_write(2'd2, 5, 1);
        wait_cnt(P-1);
        do_commit(1'b1, 1'b1);
        repeat (5) tick;
        chk("no_second_commit_pend", {127'd0, commit_pending}, 128'd0);
        chk("no_second_commit_frame", 128'(frame_cnt), 128'(exp_frame));

        // Reset during PENDING cancels the commit and clears the shadow
        do_write(2'd0, 6, 42);
        wait_cnt(10);
        commit = 1'b1;
        tick;
        commit = 1'b0;
        chk("pend_before_rst", {127'd0, commit_pending}, 128'd1);
        repeat (5) tick;
        rst = 1'b1;
        tick;
        tick;
        chk("midrst_ready", {127'd0, wr_ready}, 128'd0);
        chk("midrst_pend", {127'd0, commit_pending}, 128'd0);
        rst = 1'b0;
        model_clear();
        tick;
        chk("ready_after_midrst", {127'd0, wr_ready}, 128'd1);
        saw_done = 1'b0;
        for (int i = 0; i < P + 20; i++) begin
            saw_done |= commit_done;
            tick;
        end
        chk("no_swap_after_rst", {127'd0, saw_done}, 128'd0);
        chk("frame_after_rst", 128'(frame_cnt), 128'd0);
        chk("phase_after_rst", 128'(phase_out), 128'd0);
        chk("en_after_rst", 128'(en_out), 128'd0);
        do_commit(1'b0, 1'b0);
        chk("ch6_cleared", 128'(phase_out[6]), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
